boot_copier: RTL and testbench

BOOT_COPIER -- requirements
Module: boot_copier

---
 rtl/boot_copier.sv | 163 ++++++++++++++++
 tb/tb_boot_copier.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_copier.sv
// -----------------------------------------------------------------------------
// boot_copier
//   Copies a block of 32-bit words from one Avalon-MM word address range to
//   another. Each word is read and then written back, one at a time.
//
// Ports
//   i_Clk            system clock, rising edge
//   i_Rst            asynchronous active-high reset
//   i_Start          one-cycle copy request, sampled only while idle
//   i_SrcAddr        first source word address
//   i_DstAddr        first destination word address
//   i_Count          number of words to copy (unsigned, 0 = nothing to copy)
//   o_Busy           high from the cycle after a start until the end of DONE
//   o_Done           one-cycle completion pulse
//   o_AV_Addr        Avalon word address (0 when no request is asserted)
//   o_AV_Read        Avalon read request
//   o_AV_Write       Avalon write request
//   o_AV_WriteData   Avalon write data
//   i_AV_ReadData    Avalon read data, valid one cycle after read acceptance
//   i_AV_WaitRequest Avalon stall; a request is accepted when this is low
// -----------------------------------------------------------------------------
module boot_copier #(
  parameter int CNT_BITS = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Start,
  input  logic [29:0]         i_SrcAddr,
  input  logic [29:0]         i_DstAddr,
  input  logic [CNT_BITS-1:0] i_Count,
  output logic                o_Busy,
  output logic                o_Done,
  output logic [29:0]         o_AV_Addr,
  output logic                o_AV_Read,
  output logic                o_AV_Write,
  output logic [31:0]         o_AV_WriteData,
  input  logic [31:0]         i_AV_ReadData,
  input  logic                i_AV_WaitRequest
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t              r_State;
  logic [29:0]         r_Src;
  logic [29:0]         r_Dst;
  logic [CNT_BITS-1:0] r_Cnt;
  logic                r_Busy;
  logic                r_Done;
  logic                r_Read;
  logic                r_Write;
  logic [29:0]         r_Addr;
  logic [31:0]         r_WData;

  logic [29:0]         w_SrcNext;
  logic [29:0]         w_DstNext;
  logic                w_LastWord;

  // 30-bit adders wrap naturally from 0x3FFFFFFF to 0.
  assign w_SrcNext  = r_Src + 30'd1;
  assign w_DstNext  = r_Dst + 30'd1;
  assign w_LastWord = (r_Cnt == CNT_BITS'(1));

  // All bus outputs are registered; each transition loads the values the
  // next state must present, so requests appear the cycle the state is entered.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State <= IDLE;
      r_Src   <= '0;
      r_Dst   <= '0;
      r_Cnt   <= '0;
      r_Busy  <= 1'b0;
      r_Done  <= 1'b0;
      r_Read  <= 1'b0;
      r_Write <= 1'b0;
      r_Addr  <= '0;
      r_WData <= '0;
    end else begin
      case (r_State)
        IDLE: begin
          r_Done <= 1'b0;
          if (i_Start) begin
            r_Busy <= 1'b1;
            if (i_Count != '0) begin
              r_Src   <= i_SrcAddr;
              r_Dst   <= i_DstAddr;
              r_Cnt   <= i_Count;
              r_Read  <= 1'b1;
              r_Addr  <= i_SrcAddr;
              r_State <= RD_REQ;
            end else begin
              // Empty copy: report completion without touching the bus.
              r_Done  <= 1'b1;
              r_State <= DONE;
            end
          end
        end

        RD_REQ: begin
          if (!i_AV_WaitRequest) begin
            r_Read  <= 1'b0;
            r_Addr  <= '0;
            r_State <= RD_DATA;
          end
        end

        RD_DATA: begin
          // Fixed one-cycle read latency: the word is on the bus now.
          r_WData <= i_AV_ReadData;
          r_Write <= 1'b1;
          r_Addr  <= r_Dst;
          r_State <= WR_REQ;
        end

        WR_REQ: begin
          if (!i_AV_WaitRequest) begin
            r_Write <= 1'b0;
            r_Src   <= w_SrcNext;
            r_Dst   <= w_DstNext;
            r_Cnt   <= r_Cnt - CNT_BITS'(1);
            if (w_LastWord) begin
              r_Addr  <= '0;
              r_Done  <= 1'b1;
              r_State <= DONE;
            end else begin
              r_Read  <= 1'b1;
              r_Addr  <= w_SrcNext;
              r_State <= RD_REQ;
            end
          end
        end

        DONE: begin
          r_Done  <= 1'b0;
          r_Busy  <= 1'b0;
          r_State <= IDLE;
        end

        default: begin
          r_Read  <= 1'b0;
          r_Write <= 1'b0;
          r_Addr  <= '0;
          r_Done  <= 1'b0;
          r_Busy  <= 1'b0;
          r_State <= IDLE;
        end
      endcase
    end
  end

  assign o_Busy         = r_Busy;
  assign o_Done         = r_Done;
  assign o_AV_Addr      = r_Addr;
  assign o_AV_Read      = r_Read;
  assign o_AV_Write     = r_Write;
  assign o_AV_WriteData = r_WData;

endmodule

// File: tb/tb_boot_copier.sv
// -----------------------------------------------------------------------------
// tb_boot_copier
//   Scoreboard bench for boot_copier. Each copy request pushes the full list of
//   expected bus transfers (reads, writes, done) into a queue; a negedge
//   monitor acting as the Avalon slave pops and compares on every accepted
//   transfer and every o_Done pulse.
// -----------------------------------------------------------------------------
module tb_boot_copier;

  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_Start = 1'b0;
  logic [29:0]   i_SrcAddr = '0;
  logic [29:0]   i_DstAddr = '0;
  logic [CB-1:0] i_Count = '0;
  logic          o_Busy, o_Done, o_AV_Read, o_AV_Write;
  logic [29:0]   o_AV_Addr;
  logic [31:0]   o_AV_WriteData;
  logic [31:0]   i_AV_ReadData = '0;
  logic          i_AV_WaitRequest = 1'b0;

  boot_copier #(.CNT_BITS(CB)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(i_Start),
    .i_SrcAddr(i_SrcAddr), .i_DstAddr(i_DstAddr), .i_Count(i_Count),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_AV_Addr(o_AV_Addr),
    .o_AV_Read(o_AV_Read), .o_AV_Write(o_AV_Write),
    .o_AV_WriteData(o_AV_WriteData), .i_AV_ReadData(i_AV_ReadData),
    .i_AV_WaitRequest(i_AV_WaitRequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 read, 1 write, 2 done
    logic [29:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pat = 0;
  int          wait_mode = 0;   // 0 none, 1 three stalls, 2 random 0..2
  int          stall_cnt = 0;
  int          cur_wait = 0;
  bit          stalled = 0;
  logic [29:0] st_addr;
  logic [31:0] st_data;
  bit          st_write;
  int          first_req_cyc = -1;
  int          done_cyc = 0;
  int          start_cyc = 0;
  int          busy_cycles = 0;
  int          reads_seen = 0;
  int          writes_seen = 0;
  int          done_seen = 0;
  int          d0 = 0;

  always @(posedge clk) cyc++;

  // Slave memory contents as a pure function of the word address.
  function automatic logic [31:0] mem(input logic [29:0] a);
    if (pat == 0) return 32'hA000_0000 + {2'b00, a};
    return ({a, 2'b01} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int new_wait();
    if (wait_mode == 1) return 3;
    if (wait_mode == 2) return $urandom_range(0, 2);
    return 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input int kind, input logic [29:0] addr, input logic [31:0] data);
    txn_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_txn actual kind=%0d addr=%0h required none", kind, addr);
    end else begin
      e = exp_q.pop_front();
      check("txn_kind", kind, e.kind);
      if (kind != 2) check("txn_addr", addr, e.addr);
      if (kind == 1) check("txn_wdata", data, e.data);
    end
  endtask

  // Avalon slave + monitor.
  always @(negedge clk) begin
    if (rst) begin
      stall_cnt = 0;
      stalled = 0;
      i_AV_WaitRequest = 1'b0;
    end else begin
      if (o_Busy) busy_cycles++;
      if (o_AV_Read || o_AV_Write) begin
        check("rd_wr_exclusive", {63'd0, o_AV_Read & o_AV_Write}, 64'd0);
        if (first_req_cyc < 0) first_req_cyc = cyc;
        if (stalled) begin
          check("stall_addr", o_AV_Addr, st_addr);
          check("stall_kind", o_AV_Write, st_write);
          if (st_write) check("stall_wdata", o_AV_WriteData, st_data);
        end
        if (stall_cnt < cur_wait) begin
          i_AV_WaitRequest = 1'b1;
          stall_cnt++;
          stalled = 1;
          st_addr = o_AV_Addr;
          st_data = o_AV_WriteData;
          st_write = o_AV_Write;
        end else begin
          i_AV_WaitRequest = 1'b0;
          stalled = 0;
          stall_cnt = 0;
          cur_wait = new_wait();
          if (o_AV_Read) begin
            sb_pop(0, o_AV_Addr, '0);
            i_AV_ReadData = mem(o_AV_Addr);
            reads_seen++;
          end else begin
            sb_pop(1, o_AV_Addr, o_AV_WriteData);
            writes_seen++;
          end
        end
      end else begin
        check("idle_addr_zero", o_AV_Addr, 64'd0);
        i_AV_WaitRequest = 1'($urandom_range(0, 1));
      end
      if (o_Done) begin
        done_seen++;
        done_cyc = cyc;
        sb_pop(2, '0, '0);
      end
    end
  end

  // Reference model: a copy of cnt words is cnt (read src+i, write dst+i of
  // mem(src+i)) pairs followed by one done pulse.
  task automatic issue_copy(input logic [29:0] src, input logic [29:0] dst, input int cnt);
    txn_t t;
    logic [29:0] s, d;
    @(negedge clk); #1;
    for (int i = 0; i < cnt; i++) begin
      s = src + 30'(i);
      d = dst + 30'(i);
      t.kind = 0; t.addr = s; t.data = '0;      exp_q.push_back(t);
      t.kind = 1; t.addr = d; t.data = mem(s);  exp_q.push_back(t);
    end
    t.kind = 2; t.addr = '0; t.data = '0; exp_q.push_back(t);
    cur_wait = new_wait();
    busy_cycles = 0; first_req_cyc = -1; reads_seen = 0; writes_seen = 0;
    start_cyc = cyc; d0 = done_seen;
    i_SrcAddr = src; i_DstAddr = dst; i_Count = CB'(cnt); i_Start = 1'b1;
    @(negedge clk); #1;
    i_Start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_seen == d0; i++) begin
      @(negedge clk); #1;
    end
    check("done_timeout", {63'd0, done_seen == d0}, 64'd0);
    @(negedge clk); #1;
    check("queue_drained", exp_q.size(), 64'd0);
    check("busy_after_done", o_Busy, 64'd0);
  endtask

  task automatic pulse_start(input logic [29:0] src, input logic [29:0] dst, input int cnt);
    i_SrcAddr = src; i_DstAddr = dst; i_Count = CB'(cnt); i_Start = 1'b1;
    @(negedge clk); #1;
    i_Start = 1'b0;
  endtask

  initial begin
    int d_before;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", o_Busy, 0);
    check("rst_done", o_Done, 0);
    check("rst_read", o_AV_Read, 0);
    check("rst_write", o_AV_Write, 0);
    check("rst_addr", o_AV_Addr, 0);
    check("rst_wdata", o_AV_WriteData, 0);
    rst = 1'b0;

    // Basic 8-word copy, zero wait states.
    pat = 0; wait_mode = 0;
    issue_copy(30'h0, 30'h100, 8);
    wait_done(200);
    check("c8_req_to_done", done_cyc - first_req_cyc, 24);
    check("c8_busy_cycles", busy_cycles, 25);
    check("c8_reads", reads_seen, 8);
    check("c8_writes", writes_seen, 8);

    // Zero count.
    issue_copy(30'h123, 30'h456, 0);
    wait_done(20);
    check("c0_start_to_done", done_cyc - start_cyc, 1);
    check("c0_reads", reads_seen, 0);
    check("c0_writes", writes_seen, 0);
    check("c0_busy_cycles", busy_cycles, 1);

    // Three stall cycles on every transfer.
    pat = 1; wait_mode = 1;
    issue_copy(30'h55, 30'h2000, 2);
    wait_done(200);
    check("stall_req_to_done", done_cyc - first_req_cyc, 18);
    check("stall_writes", writes_seen, 2);

    // Address wrap.
    wait_mode = 0;
    issue_copy(30'h3FFF_FFFE, 30'h3FFF_FFFF, 3);
    wait_done(200);
    check("wrap_reads", reads_seen, 3);

    // Start while busy is ignored.
    wait_mode = 2;
    issue_copy(30'h10, 30'h20, 4);
    repeat (5) @(negedge clk);
    #1;
    pulse_start(30'h777, 30'h888, 3);
    d_before = d0;
    wait_done(300);
    repeat (10) @(negedge clk);
    #1;
    check("restart_one_done", done_seen - d_before, 1);
    check("restart_writes", writes_seen, 4);

    // Maximum count.
    issue_copy(30'($urandom), 30'($urandom), (1 << CB) - 1);
    wait_done(1000);
    check("max_writes", writes_seen, (1 << CB) - 1);

    // Reset during a write.
    issue_copy(30'h40, 30'h80, 5);
    for (int i = 0; i < 200 && !o_AV_Write; i++) begin
      @(negedge clk); #1;
    end
    check("saw_write_before_rst", o_AV_Write, 1);
    d_before = done_seen;
    #2 rst = 1'b1;
    #1;
    check("mrst_busy", o_Busy, 0);
    check("mrst_done", o_Done, 0);
    check("mrst_read", o_AV_Read, 0);
    check("mrst_write", o_AV_Write, 0);
    check("mrst_addr", o_AV_Addr, 0);
    check("mrst_wdata", o_AV_WriteData, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("mrst_no_done", done_seen - d_before, 0);
    issue_copy(30'h40, 30'h80, 5);
    wait_done(300);
    check("post_rst_writes", writes_seen, 5);

    // Randomized copies.
    for (int n = 0; n < 10; n++) begin
      logic [29:0] s;
      pat = 2 + n;
      wait_mode = $urandom_range(0, 2);
      s = ($urandom_range(0, 1) == 1) ? 30'h3FFF_FFF0 + 30'($urandom_range(0, 15)) : 30'($urandom);
      issue_copy(s, 30'($urandom), $urandom_range(0, (1 << CB) - 1));
      wait_done(1000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
